shift_xm_stage: RTL and testbench

SHIFT_XM_STAGE -- requirements
Module: shift_xm_stage

---
 rtl/shift_xm_stage.sv | 103 ++++++++++
 tb/tb_shift_xm_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_xm_stage.sv
// Shift execute stage: a combinational barrel shifter whose results are captured
// into a 2-entry skid FIFO so that upstream acceptance never depends on out_ready.
module shift_xm_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_data,
  input  logic [4:0]       in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } shift_op_e;

  logic [1:0]                  count_q, count_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [1:0][31:0]            data_q;
  logic [1:0][TAG_W-1:0]       tag_q;
  logic [1:0]                  zero_q;

  logic [31:0] shift_res;
  logic        push;
  logic        pop;

  always_comb begin
    shift_res = in_data;
    case (shift_op_e'(in_op))
      OP_SLL:  shift_res = in_data << in_shamt;
      OP_SRL:  shift_res = in_data >> in_shamt;
      OP_SRA:  shift_res = 32'($signed(in_data) >>> in_shamt);
      OP_PASS: shift_res = in_data;
      default: shift_res = in_data;
    endcase
  end

  // Ready comes from the registered count alone, keeping out_ready off the upstream path.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign busy      = out_valid;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
      zero_q   <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        data_q[wr_ptr_q] <= shift_res;
        tag_q[wr_ptr_q]  <= in_tag;
        zero_q[wr_ptr_q] <= (shift_res == 32'd0);
      end
    end
  end

  assign out_data = data_q[rd_ptr_q];
  assign out_tag  = tag_q[rd_ptr_q];
  assign out_zero = zero_q[rd_ptr_q];

endmodule

// File: tb/tb_shift_xm_stage.sv
// Scoreboard bench for shift_xm_stage: a reference queue is filled on accepted
// pushes and drained by a monitor that compares every result the stage presents.
module tb_shift_xm_stage;

  localparam int TAG_W = 5;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             zero;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [1:0]       inOp = 2'b00;
  logic [31:0]      inData = 32'd0;
  logic [4:0]       inShamt = 5'd0;
  logic [TAG_W-1:0] inTag = '0;
  logic             flushIn = 1'b0;
  logic             outValid;
  logic             outReady = 1'b0;
  logic [31:0]      outData;
  logic [TAG_W-1:0] outTag;
  logic             outZero;
  logic             busyOut;

  exp_t expQ[$];
  bit   headTaken = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  shift_xm_stage #(.TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_op     (inOp),
    .in_data   (inData),
    .in_shamt  (inShamt),
    .in_tag    (inTag),
    .flush     (flushIn),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_tag   (outTag),
    .out_zero  (outZero),
    .busy      (busyOut)
  );

  always #5 clock = ~clock;

  // Reference shift built from arithmetic: multiply, divide, floor-divide.
  function automatic logic [31:0] refShift(logic [1:0] op, logic [31:0] data, logic [4:0] shamt);
    longint u;
    longint p;
    longint s;
    longint q;
    longint r;
    u = longint'(data);
    p = longint'(1) << shamt;
    r = u;
    case (op)
      2'b00: r = (u * p) & 64'hFFFF_FFFF;
      2'b01: r = u / p;
      2'b10: begin
        s = data[31] ? (u - 64'h1_0000_0000) : u;
        if (s >= 0) q = s / p;
        else        q = -(((-s) + p - 1) / p);
        r = q & 64'hFFFF_FFFF;
      end
      default: r = u;
    endcase
    return r[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] data,
                               input logic [4:0] shamt, input logic [TAG_W-1:0] tag,
                               input logic fl, input logic ordy);
    @(posedge clock);
    #1;
    inValid  = v;
    inOp     = op;
    inData   = data;
    inShamt  = shamt;
    inTag    = tag;
    flushIn  = fl;
    outReady = ordy;
  endtask

  task automatic idle(input logic ordy, input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 2'b00, 32'd0, 5'd0, '0, 1'b0, ordy);
  endtask

  task automatic checkResetOutputs(input string tagName);
    checkOutput({tagName, "_out_valid"}, 32'(outValid), 32'd0);
    checkOutput({tagName, "_out_data"},  outData, 32'd0);
    checkOutput({tagName, "_out_tag"},   32'(outTag), 32'd0);
    checkOutput({tagName, "_out_zero"},  32'(outZero), 32'd0);
    checkOutput({tagName, "_busy"},      32'(busyOut), 32'd0);
    checkOutput({tagName, "_in_ready"},  32'(inReady), 32'd1);
  endtask

  // Reset lands between edges; outputs must collapse before any clock edge.
  task automatic pulseReset();
    @(posedge clock);
    #3;
    inValid = 1'b0;
    flushIn = 1'b0;
    reset_n = 1'b0;
    expQ.delete();
    headTaken = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("post_reset_out_data", outData, 32'd0);
    checkOutput("post_reset_out_tag", 32'(outTag), 32'd0);
    checkOutput("post_reset_out_zero", 32'(outZero), 32'd0);
  endtask

  // Model: accept when fewer than two results are held, discard everything on flush.
  always @(posedge clock) begin
    int held;
    exp_t e;
    if (reset_n) begin
      held = expQ.size() + (headTaken ? 1 : 0);
      headTaken = 1'b0;
      if (flushIn) begin
        expQ.delete();
      end else if (inValid && held != 2) begin
        e.data = refShift(inOp, inData, inShamt);
        e.tag  = inTag;
        e.zero = (e.data == 32'd0);
        expQ.push_back(e);
      end
    end
  end

  // Monitor: compare flags every cycle and the head whenever one is presented.
  always @(negedge clock) begin
    int sz;
    exp_t e;
    if (reset_n) begin
      sz = expQ.size();
      checkOutput("out_valid", 32'(outValid), 32'(sz != 0));
      checkOutput("in_ready", 32'(inReady), 32'(sz != 2));
      checkOutput("busy", 32'(busyOut), 32'(sz != 0));
      if (sz != 0 && outValid) begin
        e = expQ[0];
        checkOutput("out_data", outData, e.data);
        checkOutput("out_tag", 32'(outTag), 32'(e.tag));
        checkOutput("out_zero", 32'(outZero), 32'(e.zero));
        if (outReady) begin
          void'(expQ.pop_front());
          headTaken = 1'b1;
        end
      end
    end
  end

  initial begin
    logic [31:0] rdata;
    #2;
    checkResetOutputs("reset");
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Directed corner shifts
    applyStimulus(1'b1, 2'b00, 32'h0000_0001, 5'd31, 5'd3, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b10, 32'h8000_0000, 5'd4, 5'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b01, 32'h8000_0000, 5'd4, 5'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b00, 32'h8000_0000, 5'd1, 5'd6, 1'b0, 1'b1);
    for (int op = 0; op < 4; op++)
      applyStimulus(1'b1, 2'(op), 32'hA5A5_0F0F, 5'd0, 5'(op), 1'b0, 1'b1);
    idle(1'b1, 2);

    // Backpressure: A, B fill the FIFO while C waits
    applyStimulus(1'b1, 2'b11, 32'h0000_000A, 5'd0, 5'd10, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'h0000_000B, 5'd0, 5'd11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'h0000_000C, 5'd0, 5'd12, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'h0000_000C, 5'd0, 5'd12, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'h0000_000C, 5'd0, 5'd12, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b11, 32'h0000_000C, 5'd0, 5'd12, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Streaming at count=1 with simultaneous push and pop
    applyStimulus(1'b1, 2'b01, 32'hFFFF_0000, 5'd8, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++)
      applyStimulus(1'b1, 2'b01, 32'hFFFF_0000, 5'(i), 5'(i), 1'b0, 1'b1);
    idle(1'b1, 2);

    // Flush with a full FIFO and a valid input
    applyStimulus(1'b1, 2'b11, 32'h1111_1111, 5'd0, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'h2222_2222, 5'd0, 5'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'h3333_3333, 5'd0, 5'd3, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'b11, 32'h1234_5678, 5'd7, 5'd9, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Reset in the middle of a full FIFO
    applyStimulus(1'b1, 2'b00, 32'h0000_00FF, 5'd4, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 32'h0000_FF00, 5'd4, 5'd2, 1'b0, 1'b0);
    pulseReset();
    applyStimulus(1'b1, 2'b10, 32'hF000_0000, 5'd28, 5'd17, 1'b0, 1'b1);
    idle(1'b1, 2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       rdata = 32'h8000_0000;
        1:       rdata = 32'h0000_0001;
        default: rdata = $urandom;
      endcase
      applyStimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), rdata,
                    5'($urandom_range(0, 31)), TAG_W'($urandom),
                    $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);
    end

    idle(1'b1, 6);
    @(negedge clock);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
